// File: rtl/uart_pkg.sv
// uart_pkg: shared register map, CON flag positions and transmitter state encoding.
package uart_pkg;
    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;
    localparam int CON_BUSY = 0;
    localparam int CON_FULL = 1;
    localparam int CON_OVR  = 2;
    localparam int CON_DONE = 3;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    // Registers are word-aligned, so the byte offset bits never take part in decode.
    function automatic logic reg_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:2] == base[31:2];
    endfunction
endpackage

// File: rtl/uart_tx_periph_if.sv
// uart_tx_periph_if: data-memory bus seen by the UART peripheral.
interface uart_tx_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        memwrite;
    logic        memread;
    modport master (output addr, wdata, memwrite, memread, input rdata);
    modport slave  (input addr, wdata, memwrite, memread, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO; a push while full is rejected even if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter (TXD write, CON status).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the shifter.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_periph_if.slave bus,
    output logic            tx,
    output logic            tx_done
);
    localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

    tx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  next_byte;
    logic [31:0] con;
    logic        ovr;
    logic        done;
    logic        busy;
    logic        full;
    logic        wr_txd;
    logic        rd_con;
    logic        wr_ok;
    logic        stop_end;
    logic        take;

    assign busy     = state != IDLE;
    assign wr_txd   = bus.memwrite && reg_hit(bus.addr, UART_TXD_ADDR);
    assign rd_con   = bus.memread && reg_hit(bus.addr, UART_CON_ADDR);
    assign wr_ok    = wr_txd && !full;
    assign stop_end = state == STOP && cnt == '0;

`ifdef UART_TX_FIFO_EN
    logic                         load;
    logic                         fifo_empty;
    logic [7:0]                   fifo_head;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         unused_bits;

    // An empty FIFO is bypassed so an idle line starts on the edge after the write.
    assign load      = state == IDLE || stop_end;
    assign take      = load && (!fifo_empty || wr_ok);
    assign next_byte = fifo_empty ? bus.wdata[7:0] : fifo_head;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_ok && !(load && fifo_empty)),
        .pop   (load && !fifo_empty),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_head),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    assign unused_bits = &{1'b0, fifo_count, bus.wdata[31:8]};
`else
    localparam int unused_depth = FIFO_DEPTH;
    logic          unused_bits;

    assign full        = busy;
    assign take        = wr_ok;
    assign next_byte   = bus.wdata[7:0];
    assign unused_bits = &{1'b0, bus.wdata[31:8]};
`endif

    always_comb begin
        con           = '0;
        con[CON_BUSY] = busy;
        con[CON_FULL] = full;
        con[CON_OVR]  = ovr;
        con[CON_DONE] = done;
    end

    assign bus.rdata = (!reset && reg_hit(bus.addr, UART_CON_ADDR)) ? con : '0;

    // Sticky flags: a set in the same cycle as a CON read wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ovr     <= 1'b0;
            done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            ovr     <= (wr_txd && full) || (ovr && !rd_con);
            done    <= stop_end || (done && !rd_con);
            case (state)
                IDLE: begin
                    if (take) begin
                        state <= START;
                        tx    <= 1'b0;
                        shreg <= next_byte;
                        cnt   <= RELOAD;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        cnt     <= RELOAD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        state   <= bit_idx == 3'd7 ? STOP : DATA;
                        tx      <= bit_idx == 3'd7 ? 1'b1 : shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= RELOAD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        tx_done <= 1'b1;
                        state   <= take ? START : IDLE;
                        tx      <= !take;
                        shreg   <= take ? next_byte : shreg;
                        cnt     <= take ? RELOAD : '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
